// File: rtl/mig_write_issuer.sv
// Phrase-stream to MIG write issuer: one-entry holding slot with independent command/data handshakes.
// Optional DOUBLE_BUFFER_EN: ping-pong between two frame buffers, switching on each frame start.
module mig_write_issuer #(
  parameter int ADDR_W           = 27,
  parameter int BASE_ADDR        = 0,
  parameter int FRAME_WORDS      = 921600,
  parameter int WORDS_PER_PHRASE = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_phrase,
  output logic              ready_phrase,
  input  logic [127:0]      phrase_data,
  input  logic              phrase_tuser,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [15:0]       app_wdf_mask,
  input  logic              app_wdf_rdy,
  output logic              frame_wrap_out,
  output logic              buf_sel_out
);

  localparam logic [ADDR_W:0]   FRAME_W  = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0]   BASE_W   = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]   STEP_W   = (ADDR_W+1)'(WORDS_PER_PHRASE);
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(FRAME_WORDS - WORDS_PER_PHRASE);

  logic              full, cmd_pend, wdf_pend, buf_q;
  logic [ADDR_W-1:0] offset, addr_q;
  logic [127:0]      data_q;

  logic              cmd_done, wdf_done, retire, accept, buf_next;
  logic [ADDR_W:0]   off_inc, addr_wide;
  logic [ADDR_W-1:0] next_off, off_sel;

  assign app_en       = full && cmd_pend;
  assign app_wdf_wren = full && wdf_pend;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = 3'b000;
  assign app_wdf_mask = 16'h0000;
  assign app_addr     = addr_q;
  assign app_wdf_data = data_q;
  assign buf_sel_out  = buf_q;

  // The slot frees only once both handshakes are done; a handshake already
  // completed in an earlier cycle counts as done.
  assign cmd_done     = app_en && app_rdy;
  assign wdf_done     = app_wdf_wren && app_wdf_rdy;
  assign retire       = full && (cmd_done || !cmd_pend) && (wdf_done || !wdf_pend);
  assign ready_phrase = !full || retire;
  assign accept       = valid_phrase && ready_phrase;

  assign frame_wrap_out = retire && (offset == LAST_OFF);

  always_comb begin
    off_inc  = {1'b0, offset} + STEP_W;
    next_off = (off_inc >= FRAME_W) ? '0 : off_inc[ADDR_W-1:0];
    off_sel  = phrase_tuser ? '0 : next_off;
`ifdef DOUBLE_BUFFER_EN
    buf_next = buf_q ^ phrase_tuser;
`else
    buf_next = 1'b0;
`endif
    addr_wide = BASE_W + (buf_next ? FRAME_W : '0) + {1'b0, off_sel};
  end

  // NOTE: state uses non-blocking assignments and every register, including
  // the data slot, is cleared by the async reset so a discarded phrase never leaks out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full     <= 1'b0;
      cmd_pend <= 1'b0;
      wdf_pend <= 1'b0;
      buf_q    <= 1'b0;
      offset   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (accept) begin
      full     <= 1'b1;
      cmd_pend <= 1'b1;
      wdf_pend <= 1'b1;
      buf_q    <= buf_next;
      offset   <= off_sel;
      addr_q   <= addr_wide[ADDR_W-1:0];
      data_q   <= phrase_data;
    end else begin
      if (cmd_done) cmd_pend <= 1'b0;
      if (wdf_done) wdf_pend <= 1'b0;
      if (retire)   full     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mig_write_issuer.sv
// Directed self-checking bench for mig_write_issuer with a 32-word frame.
// Works in both builds; expected addresses follow DOUBLE_BUFFER_EN when it is defined.
module tb_mig_write_issuer;
  localparam int FW = 32;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         valid_phrase = 1'b0;
  logic         ready_phrase;
  logic [127:0] phrase_data = '0;
  logic         phrase_tuser = 1'b0;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy = 1'b0;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy = 1'b0;
  logic         frame_wrap_out;
  logic         buf_sel_out;

  mig_write_issuer #(.ADDR_W(27), .BASE_ADDR(0), .FRAME_WORDS(FW), .WORDS_PER_PHRASE(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .valid_phrase(valid_phrase), .ready_phrase(ready_phrase),
    .phrase_data(phrase_data), .phrase_tuser(phrase_tuser),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .frame_wrap_out(frame_wrap_out), .buf_sel_out(buf_sel_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfers observed at the negedge before the posedge that completes them.
  logic [26:0]  cmd_q[$];
  int           cmd_cyc[$];
  logic [127:0] wdf_q[$];
  logic [26:0]  wrap_q[$];
  logic [127:0] sent_q[$];
  logic [26:0]  base_q[$];
  int           stalls = 0;
  int           cyc = 0;
  bit           exp_buf = 1'b0;

  always @(negedge clk_in) begin
    cyc++;
    if (app_en && app_rdy) begin
      cmd_q.push_back(app_addr);
      cmd_cyc.push_back(cyc);
    end
    if (app_wdf_wren && app_wdf_rdy) wdf_q.push_back(app_wdf_data);
    if (frame_wrap_out) wrap_q.push_back(app_addr);
    if (valid_phrase && !ready_phrase) stalls++;
  end

  task automatic clear();
    cmd_q.delete(); cmd_cyc.delete(); wdf_q.delete(); wrap_q.delete();
    sent_q.delete(); base_q.delete(); stalls = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the phrase was accepted.
  task automatic send(input logic [127:0] d, input bit tu);
    bit ok = 1'b0;
`ifdef DOUBLE_BUFFER_EN
    if (tu) exp_buf = ~exp_buf;
`endif
    base_q.push_back(exp_buf ? 27'(FW) : 27'd0);
    sent_q.push_back(d);
    valid_phrase = 1'b1; phrase_data = d; phrase_tuser = tu;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_in);
      if (ready_phrase) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk_in); #1;
    valid_phrase = 1'b0; phrase_tuser = 1'b0;
  endtask

  task automatic expect_cmds(input string tag, input int n,
                             input int o0, input int o1, input int o2, input int o3, input int o4);
    int offs[5];
    offs = '{o0, o1, o2, o3, o4};
    check({tag, "_ncmd"}, cmd_q.size(), n);
    check({tag, "_nwdf"}, wdf_q.size(), n);
    for (int i = 0; i < n && i < cmd_q.size() && i < wdf_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), cmd_q[i], base_q[i] + 27'(offs[i]));
      check($sformatf("%s_data%0d", tag, i), wdf_q[i], sent_q[i]);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0; exp_buf = 1'b0;
    idle(2);
    rst_in = 1'b1;
    idle(1);
  endtask

  initial begin
    do_reset();
    check("rst_app_en", app_en, 0);
    check("rst_wren", app_wdf_wren, 0);
    check("rst_ready", ready_phrase, 1);
    check("rst_wrap", frame_wrap_out, 0);
    check("rst_buf", buf_sel_out, 0);
    check("rst_addr", app_addr, 0);
    check("rst_data", app_wdf_data, 0);
    check("rst_cmd", app_cmd, 0);
    check("rst_mask", app_wdf_mask, 0);

    // Back-to-back at full rate.
    clear(); app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send({4{32'hA000_0000 + 32'(i)}}, i == 0);
    idle(3);
    expect_cmds("b2b", 4, 0, 8, 16, 24, 0);
    check("b2b_stalls", stalls, 0);
    if (cmd_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check($sformatf("b2b_cyc%0d", i), cmd_cyc[i], cmd_cyc[0] + i);
    check("b2b_wrap_n", wrap_q.size(), 1);

    // Command stalled 3 cycles while write data goes through at once.
    clear(); app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    send(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check($sformatf("stall_en%0d", i), app_en, 1);
      check($sformatf("stall_addr%0d", i), app_addr, base_q[0]);
      check($sformatf("stall_wren%0d", i), app_wdf_wren, i == 0);
      check($sformatf("stall_wdf_end%0d", i), app_wdf_end, i == 0);
      check($sformatf("stall_ready%0d", i), ready_phrase, 0);
    end
    @(posedge clk_in); #1; app_rdy = 1'b1;
    @(negedge clk_in);
    check("stall_ready_retire", ready_phrase, 1);
    @(posedge clk_in); #1;
    check("stall_en_off", app_en, 0);
    expect_cmds("stall", 1, 0, 0, 0, 0, 0);

    // Frame wrap after 4 phrases.
    clear();
    for (int i = 0; i < 5; i++) send({4{32'hB000_0000 + 32'(i)}}, i == 0);
    idle(3);
    expect_cmds("wrap", 5, 0, 8, 16, 24, 0);
    check("wrap_n", wrap_q.size(), 1);
    if (wrap_q.size() >= 1) check("wrap_addr", wrap_q[0], base_q[3] + 27'd24);

    // Truncated frame restarts on tuser, no wrap pulse.
    clear(); idle(1);
    send(128'hC0, 1'b1); send(128'hC1, 1'b0); send(128'hC2, 1'b1);
    idle(3);
    expect_cmds("trunc", 3, 0, 8, 0, 0, 0);
    check("trunc_wrap_n", wrap_q.size(), 0);

    // Reset while stalled.
    clear(); app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    send(128'hDEAD, 1'b1);
    check("pre_rst_en", app_en, 1);
    rst_in = 1'b0; exp_buf = 1'b0; #1;
    check("mid_rst_en", app_en, 0);
    check("mid_rst_wren", app_wdf_wren, 0);
    check("mid_rst_ready", ready_phrase, 1);
    check("mid_rst_buf", buf_sel_out, 0);
    idle(2); rst_in = 1'b1; idle(1);
    clear(); app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    send(128'hBEEF, 1'b1);
    idle(3);
    expect_cmds("post_rst", 1, 0, 0, 0, 0, 0);

    // Two full frames: in the double-buffered build they land at 32.. then 0..
    do_reset(); clear();
    for (int i = 0; i < 4; i++) send({4{32'hE100_0000 + 32'(i)}}, i == 0);
    idle(3);
    expect_cmds("frm1", 4, 0, 8, 16, 24, 0);
    check("frm1_buf", buf_sel_out, exp_buf);
    check("frm1_wrap_n", wrap_q.size(), 1);
    clear();
    for (int i = 0; i < 4; i++) send({4{32'hE200_0000 + 32'(i)}}, i == 0);
    idle(3);
    expect_cmds("frm2", 4, 0, 8, 16, 24, 0);
    check("frm2_buf", buf_sel_out, exp_buf);
    check("frm2_wrap_n", wrap_q.size(), 1);
    if (wrap_q.size() >= 1) check("frm2_wrap_addr", wrap_q[0], base_q[3] + 27'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
